// File: rtl/alu_pkg.sv
// Shared types and constants for the iterative divider.
// Holds the FSM state enum, default width and count-width helper.
package alu_pkg;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } state_t;

  function automatic int cnt_w(input int w);
    return $clog2(w) + 1;
  endfunction

  localparam int CNT_W = cnt_w(WIDTH_DEF);

endpackage

// File: rtl/alu_divider_if.sv
// Request/result bundle of the divider.
// master drives start/operands; slave returns busy/done/results.
interface alu_divider_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic             signed_op;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, signed_op, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, signed_op, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/div_step.sv
// One restoring-division step: shift in a dividend bit, trial subtract.
// Ports: rem_in/bit_in/divisor in; rem_out and q_bit out.
module div_step
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH:0]   rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH:0]   rem_out,
  output logic             q_bit
);

  logic [WIDTH+1:0] trial;
  logic [WIDTH+1:0] diff;

  assign trial = {rem_in, bit_in};
  assign diff  = trial - {2'b00, divisor};

  // Top bit of diff is the borrow: set means trial < divisor.
  assign q_bit   = ~diff[WIDTH+1];
  assign rem_out = q_bit ? diff[WIDTH:0] : trial[WIDTH:0];

endmodule

// File: rtl/alu_divider.sv
// Multi-cycle signed/unsigned restoring divider, fixed latency.
// Ports: clk, rst_n (sync, active low), bus (slave side of alu_divider_if).
module alu_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input logic         clk,
  input logic         rst_n,
  alu_divider_if.slave bus
);

  localparam int CW = cnt_w(WIDTH);

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] dq;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   pr;
  logic             q_neg;
  logic             r_neg;

  logic [WIDTH:0]   pr_nxt;
  logic             q_bit;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign a_neg = bus.signed_op & bus.dividend[WIDTH-1];
  assign b_neg = bus.signed_op & bus.divisor[WIDTH-1];
  assign a_mag = a_neg ? -bus.dividend : bus.dividend;
  assign b_mag = b_neg ? -bus.divisor : bus.divisor;

  // dq holds the dividend magnitude; quotient bits shift in from the right.
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (pr),
    .bit_in  (dq[WIDTH-1]),
    .divisor (dvs),
    .rem_out (pr_nxt),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      count           <= '0;
      dq              <= '0;
      dvs             <= '0;
      pr              <= '0;
      q_neg           <= 1'b0;
      r_neg           <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            bus.busy <= 1'b1;
            count    <= '0;
            dq       <= a_mag;
            dvs      <= b_mag;
            pr       <= '0;
            q_neg    <= a_neg ^ b_neg;
            r_neg    <= a_neg;
            if (bus.divisor == '0) begin
              state           <= DONE;
              bus.done        <= 1'b1;
              bus.quotient    <= '1;
              bus.remainder   <= bus.dividend;
              bus.div_by_zero <= 1'b1;
            end else begin
              state           <= RUN;
              bus.quotient    <= '0;
              bus.remainder   <= '0;
              bus.div_by_zero <= 1'b0;
            end
          end
        end
        RUN: begin
          pr    <= pr_nxt;
          dq    <= {dq[WIDTH-2:0], q_bit};
          count <= count + CW'(1);
          if (count == CW'(WIDTH - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          bus.quotient  <= q_neg ? -dq : dq;
          bus.remainder <= r_neg ? -pr[WIDTH-1:0] : pr[WIDTH-1:0];
          bus.done      <= 1'b1;
          state         <= DONE;
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_divider.sv
// Scoreboard bench for alu_divider: directed vectors, queued expectations.
// A negedge monitor pops and checks every done pulse.
module tb_alu_divider;

  logic clk;
  logic rst_n;
  int   cyc;
  int   checks;
  int   failures;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    int          cyc0;
    int          lat;
    string       name;
  } exp_t;

  exp_t sb[$];

  alu_divider_if #(.WIDTH(32)) bus ();

  alu_divider #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.done === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done actual=1 required=0 cyc=%0d", cyc);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_q"}, bus.quotient, e.q);
        chk({e.name, "_r"}, bus.remainder, e.r);
        chk({e.name, "_dbz"}, {31'b0, bus.div_by_zero}, {31'b0, e.dbz});
        chk({e.name, "_lat"}, cyc - e.cyc0, e.lat);
      end
    end
  end

  task automatic run(input string name, input logic sgn,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] q, input logic [31:0] r,
                     input logic dbz, input bit poke_mid,
                     input bit poke_done);
    int n;
    @(negedge clk);
    bus.start     = 1'b1;
    bus.signed_op = sgn;
    bus.dividend  = a;
    bus.divisor   = b;
    sb.push_back('{q, r, dbz, cyc, dbz ? 1 : 34, name});
    @(negedge clk);
    bus.start = 1'b0;
    chk({name, "_busy"}, {31'b0, bus.busy}, 32'd1);
    if (!dbz) chk({name, "_clr"}, bus.quotient, 32'd0);
    if (poke_mid) begin
      repeat (3) @(negedge clk);
      bus.start     = 1'b1;
      bus.signed_op = 1'b0;
      bus.dividend  = 32'd1;
      bus.divisor   = 32'd1;
      @(negedge clk);
      bus.start = 1'b0;
    end
    n = 0;
    while (bus.busy && n < 60) begin
      if (bus.done && poke_done) begin
        bus.start    = 1'b1;
        bus.dividend = 32'd1;
        bus.divisor  = 32'd1;
      end
      @(negedge clk);
      bus.start = 1'b0;
      n++;
    end
    if (bus.busy) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=busy required=idle", name);
    end
    repeat (2) @(negedge clk);
    chk({name, "_hold_q"}, bus.quotient, q);
    chk({name, "_hold_r"}, bus.remainder, r);
  endtask

  initial begin
    checks        = 0;
    failures      = 0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.signed_op = 1'b0;
    bus.dividend  = '0;
    bus.divisor   = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'b0, bus.busy}, 32'd0);
    chk("rst_done", {31'b0, bus.done}, 32'd0);
    chk("rst_q", bus.quotient, 32'd0);
    chk("rst_r", bus.remainder, 32'd0);
    chk("rst_dbz", {31'b0, bus.div_by_zero}, 32'd0);
    rst_n = 1'b1;

    run("u100_7", 0, 32'd100, 32'd7, 32'd14, 32'd2, 0, 0, 0);
    run("s_m7_2", 1, 32'hFFFFFFF9, 32'd2,
        32'hFFFFFFFD, 32'hFFFFFFFF, 0, 0, 0);
    run("s_ovf", 1, 32'h80000000, 32'hFFFFFFFF,
        32'h80000000, 32'd0, 0, 0, 0);
    run("u5_0", 0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 1, 0, 1);
    run("s_m7_0", 1, 32'hFFFFFFF9, 32'd0,
        32'hFFFFFFFF, 32'hFFFFFFF9, 1, 0, 0);
    run("u_busy_poke", 0, 32'hFFFFFFFF, 32'd3,
        32'h55555555, 32'd0, 0, 1, 1);
    run("s7_m2", 1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 0, 0, 0);
    run("s_m8_m3", 1, 32'hFFFFFFF8, 32'hFFFFFFFD,
        32'd2, 32'hFFFFFFFE, 0, 0, 0);
    run("s_m6_3", 1, 32'hFFFFFFFA, 32'd3, 32'hFFFFFFFE, 32'd0, 0, 0, 0);
    run("u_max_1", 0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 0, 0, 0);
    run("u3_10", 0, 32'd3, 32'd10, 32'd0, 32'd3, 0, 0, 0);
    run("u_big", 0, 32'h80000000, 32'hFFFFFFFF,
        32'd0, 32'h80000000, 0, 0, 0);

    @(negedge clk);
    bus.start     = 1'b1;
    bus.signed_op = 1'b0;
    bus.dividend  = 32'd100;
    bus.divisor   = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'b0, bus.busy}, 32'd0);
    chk("abort_done", {31'b0, bus.done}, 32'd0);
    chk("abort_q", bus.quotient, 32'd0);
    chk("abort_r", bus.remainder, 32'd0);
    chk("abort_dbz", {31'b0, bus.div_by_zero}, 32'd0);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("abort_idle", {31'b0, bus.busy}, 32'd0);
    run("u9_3", 0, 32'd9, 32'd3, 32'd3, 32'd0, 0, 0, 0);

    repeat (3) @(negedge clk);
    chk("sb_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_divider.md
ALU_DIVIDER -- requirements
Module: alu_divider

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-004 The block SHALL have port start, input, 1 bit: request a division; sampled only when busy=0.
REQ-005 The block SHALL have port signed_op, input, 1 bit: 1 selects two's-complement operands, 0 selects unsigned; sampled with start.
REQ-006 The block SHALL have port dividend, input, WIDTH bits: numerator; sampled with start.
REQ-007 The block SHALL have port divisor, input, WIDTH bits: denominator; sampled with start.
REQ-008 The block SHALL have port busy, output, 1 bit: operation in progress; high from the edge after start is accepted through the DONE cycle.
REQ-009 The block SHALL have port done, output, 1 bit: single-cycle pulse; results valid.
REQ-010 The block SHALL have port quotient, output, WIDTH bits: result quotient.
REQ-011 The block SHALL have port remainder, output, WIDTH bits: result remainder.
REQ-012 The block SHALL have port div_by_zero, output, 1 bit: set with done when divisor=0.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, RUN, FIX, DONE.
REQ-014 In IDLE with start=1, the block SHALL latch operands, go to RUN with iteration count 0, or go directly to DONE if divisor=0.
REQ-015 RUN SHALL perform one restoring shift/conditional-subtract step per cycle on operand magnitudes, for exactly WIDTH cycles, then go to FIX.
REQ-016 FIX SHALL apply sign correction in one cycle, then go to DONE.
REQ-017 DONE SHALL assert done=1 for one cycle, then return to IDLE.
REQ-018 Latency SHALL be fixed: done=1 exactly WIDTH+2 cycles (34 at default) after the edge that samples start.
REQ-019 Latency for a zero divisor SHALL be 1 cycle.
REQ-020 start while busy=1 SHALL be ignored, with no queuing.
REQ-021 start in the DONE cycle SHALL be ignored.
REQ-022 Signed division SHALL truncate toward zero; the remainder sign SHALL equal the dividend sign; remainder=0 SHALL never carry a sign.
REQ-023 Signed overflow (most-negative / -1) SHALL yield quotient=most-negative and remainder=0, with no flag.
REQ-024 Divide by zero, signed or unsigned, SHALL yield quotient all-ones, remainder=dividend, div_by_zero=1.
REQ-025 quotient, remainder and div_by_zero SHALL hold their values from DONE until the next accepted start, then clear to 0 on that accept edge.
REQ-026 Internal arithmetic SHALL use a WIDTH+1-bit partial remainder so the subtract borrow is explicit; no overflow is possible.

Reset
REQ-027 When rst_n=0 at a clock edge, the block SHALL enter IDLE and set busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, count=0.
REQ-028 Reset mid-operation (RUN/FIX/DONE) SHALL abort with no done pulse; the first start after rst_n returns high SHALL be handled normally.
REQ-029 rst_n SHALL take priority over start on the same edge.

Structure
REQ-030 Package alu_pkg SHALL hold the FSM state enum, the default WIDTH constant, and the count width, computed as clog2(WIDTH)+1.
REQ-031 One combinational sub-module, div_step, SHALL implement a single shift/trial-subtract step (inputs: partial remainder, next dividend bit, divisor; outputs: new partial remainder, quotient bit); it is instantiated once.

Verification
REQ-032 Unsigned 100/7 -> quotient=14, remainder=2, div_by_zero=0, done exactly 34 cycles after start.
REQ-033 Signed -7/2 (0xFFFFFFF9/0x00000002) -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF.
REQ-034 Signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0, div_by_zero=0.
REQ-035 Unsigned 5/0 -> done 1 cycle after start, quotient=0xFFFFFFFF, remainder=5, div_by_zero=1.
REQ-036 Start 0xFFFFFFFF/3 unsigned; pulse start with 1/1 at cycle 5 -> second start ignored, result quotient=0x55555555, remainder=0.
REQ-037 Start any division; rst_n=0 at cycle 10 -> busy=0 and all outputs 0 next cycle, no done; a following 9/3 -> quotient=3, remainder=0.
